// File: rtl/lockout_pulse_timer_if.sv
// Control/status bundle for lockout_pulse_timer: trigger side in, per-channel status out.
interface lockout_pulse_timer_if #(
  parameter int unsigned CH = 4
);
  logic          en;
  logic [CH-1:0] trig;
  logic [CH-1:0] clr_miss;
  logic [CH-1:0] pulse;
  logic [CH-1:0] busy;
  logic [CH-1:0] miss;
  logic          any_pulse;

  modport master (
    output en, trig, clr_miss,
    input  pulse, busy, miss, any_pulse
  );

  modport slave (
    input  en, trig, clr_miss,
    output pulse, busy, miss, any_pulse
  );
endinterface

// File: rtl/lockout_pulse_timer.sv
// N-channel one-shot pulse generator: fires once per qualified trigger, then holds
// a programmable lockout window that either drops (and flags) or restarts on new triggers.
module lockout_pulse_timer #(
  parameter int unsigned CH          = 4,
  parameter int unsigned CW          = 5,
  parameter int unsigned LOCK_CYCLES = 15,
  parameter int unsigned RETRIG      = 0,
  parameter int unsigned EDGE        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lockout_pulse_timer_if.slave  bus
);

  localparam logic [CW-1:0] LOAD = CW'(LOCK_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [CH-1:0] prev;
  logic [CH-1:0] qual;
  logic [CH-1:0] pulse_q;
  logic [CH-1:0] busy_q;
  logic [CH-1:0] miss_q;

  // Trigger history is tracked even while disabled so re-enable sees true edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= bus.trig;
    end
  end

  assign qual = (EDGE != 0) ? (bus.trig & ~prev) : bus.trig;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pulse_r;
    logic          busy_r;
    logic          miss_r;
    logic          miss_set;

    // A trigger on the expiring edge is neither a refire nor a drop.
    assign miss_set = bus.en && (state == HOLD) && (cnt != ONE) && qual[i] && (RETRIG == 0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        pulse_r <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        if (bus.en) begin
          case (state)
            IDLE: begin
              if (qual[i]) begin
                state   <= HOLD;
                pulse_r <= 1'b1;
                busy_r  <= 1'b1;
                cnt     <= LOAD;
              end
            end
            HOLD: begin
              if (cnt == ONE) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                cnt    <= '0;
              end else if (qual[i] && (RETRIG != 0)) begin
                cnt <= LOAD;
              end else begin
                cnt <= cnt - ONE;
              end
            end
            default: begin
              state  <= IDLE;
              busy_r <= 1'b0;
              cnt    <= '0;
            end
          endcase
        end
      end
    end

    // Sticky drop flag; a set wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        miss_r <= 1'b0;
      end else if (miss_set) begin
        miss_r <= 1'b1;
      end else if (bus.clr_miss[i]) begin
        miss_r <= 1'b0;
      end
    end

    assign pulse_q[i] = pulse_r;
    assign busy_q[i]  = busy_r;
    assign miss_q[i]  = miss_r;
  end

  assign bus.pulse     = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.miss      = miss_q;
  assign bus.any_pulse = |pulse_q;

endmodule

// File: tb/tb_lockout_pulse_timer.sv
// Directed bench for lockout_pulse_timer across four parameter sets sharing one clock/reset.
module tb_lockout_pulse_timer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  lockout_pulse_timer_if #(.CH(4)) if_a ();
  lockout_pulse_timer_if #(.CH(4)) if_r ();
  lockout_pulse_timer_if #(.CH(4)) if_e ();
  lockout_pulse_timer_if #(.CH(4)) if_1 ();

  lockout_pulse_timer #(.CH(4), .CW(5), .LOCK_CYCLES(3), .RETRIG(0), .EDGE(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  lockout_pulse_timer #(.CH(4), .CW(5), .LOCK_CYCLES(4), .RETRIG(1), .EDGE(0))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));
  lockout_pulse_timer #(.CH(4), .CW(5), .LOCK_CYCLES(3), .RETRIG(0), .EDGE(1))
    dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e));
  lockout_pulse_timer #(.CH(4), .CW(5), .LOCK_CYCLES(1), .RETRIG(0), .EDGE(0))
    dut_1 (.clk(clk), .rst_n(rst_n), .bus(if_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [51:0] all_outs();
    return {if_a.pulse, if_a.busy, if_a.miss, if_a.any_pulse,
            if_r.pulse, if_r.busy, if_r.miss, if_r.any_pulse,
            if_e.pulse, if_e.busy, if_e.miss, if_e.any_pulse,
            if_1.pulse, if_1.busy, if_1.miss, if_1.any_pulse};
  endfunction

  task automatic test_reset();
    logic [51:0] o;
    o = all_outs();
    checks++;
    if (o !== 52'h0) begin
      failures++;
      $display("FAIL reset_initial: outputs=%h required=0", o);
    end
    if_a.trig = 4'b0001;
    tick();
    checks++;
    if (if_a.pulse !== 4'b0001 || if_a.busy !== 4'b0001) begin
      failures++;
      $display("FAIL reset_prefire: pulse=%b busy=%b required 0001/0001", if_a.pulse, if_a.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    o = all_outs();
    checks++;
    if (o !== 52'h0) begin
      failures++;
      $display("FAIL reset_async: outputs=%h required=0", o);
    end
    if_a.trig = 4'b0000;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      o = all_outs();
      checks++;
      if (o !== 52'h0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: outputs=%h required=0", c, o);
      end
    end
  endtask

  task automatic test_single_fire();
    logic [3:0] exp_pulse [4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] exp_busy  [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    if_a.trig = 4'b0100;
    for (int e = 0; e < 4; e++) begin
      tick();
      if_a.trig = 4'b0000;
      checks++;
      if (if_a.pulse !== exp_pulse[e] || if_a.busy !== exp_busy[e] ||
          if_a.any_pulse !== (e == 0)) begin
        failures++;
        $display("FAIL single_fire e%0d: pulse=%b busy=%b any=%b required %b/%b/%b",
                 e, if_a.pulse, if_a.busy, if_a.any_pulse, exp_pulse[e], exp_busy[e], e == 0);
      end
    end
  endtask

  task automatic test_held_level();
    logic ep, eb, em;
    if_a.trig = 4'b0001;
    for (int e = 0; e < 12; e++) begin
      if_a.clr_miss = (e == 9) ? 4'b0001 : 4'b0000;
      tick();
      ep = ((e % 4) == 0);
      eb = ((e % 4) != 3);
      em = (e >= 1);
      checks++;
      if (if_a.pulse[0] !== ep || if_a.busy[0] !== eb || if_a.miss !== {3'b000, em}) begin
        failures++;
        $display("FAIL held_level e%0d: pulse0=%b busy0=%b miss=%b required %b/%b/000%b",
                 e, if_a.pulse[0], if_a.busy[0], if_a.miss, ep, eb, em);
      end
    end
    if_a.trig = 4'b0000;
    if_a.clr_miss = 4'b0001;
    tick();
    if_a.clr_miss = 4'b0000;
    checks++;
    if (if_a.miss !== 4'b0000) begin
      failures++;
      $display("FAIL miss_clear: miss=%b required=0000", if_a.miss);
    end
  endtask

  task automatic test_retrigger();
    logic tseq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic bexp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int e = 0; e < 8; e++) begin
      if_r.trig = {tseq[e], 3'b000};
      tick();
      checks++;
      if (if_r.pulse[3] !== (e == 0) || if_r.busy[3] !== bexp[e] || if_r.miss !== 4'b0000) begin
        failures++;
        $display("FAIL retrigger e%0d: pulse3=%b busy3=%b miss=%b required %b/%b/0000",
                 e, if_r.pulse[3], if_r.busy[3], if_r.miss, e == 0, bexp[e]);
      end
    end
    if_r.trig = 4'b0000;
  endtask

  task automatic test_edge_mode();
    int npulse;
    npulse = 0;
    if_e.trig = 4'b0010;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (if_e.pulse[1] === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 1 || if_e.miss !== 4'b0000) begin
      failures++;
      $display("FAIL edge_held: pulses=%0d miss=%b required 1/0000", npulse, if_e.miss);
    end
    if_e.trig = 4'b0000;
    tick();
    checks++;
    if (if_e.pulse !== 4'b0000) begin
      failures++;
      $display("FAIL edge_low: pulse=%b required=0000", if_e.pulse);
    end
    if_e.trig = 4'b0010;
    tick();
    checks++;
    if (if_e.pulse !== 4'b0010 || if_e.busy !== 4'b0010) begin
      failures++;
      $display("FAIL edge_refire: pulse=%b busy=%b required 0010/0010", if_e.pulse, if_e.busy);
    end
    if_e.trig = 4'b0000;
  endtask

  task automatic test_lock_one();
    if_1.trig = 4'b0001;
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (if_1.pulse[0] !== ((e % 2) == 0) || if_1.busy[0] !== ((e % 2) == 0)) begin
        failures++;
        $display("FAIL lock_one e%0d: pulse0=%b busy0=%b required %b/%b",
                 e, if_1.pulse[0], if_1.busy[0], (e % 2) == 0, (e % 2) == 0);
      end
    end
    if_1.trig = 4'b0000;
    tick();
  endtask

  task automatic test_enable_freeze();
    if_a.trig = 4'b0100;
    tick();
    if_a.trig = 4'b0000;
    tick();
    if_a.en = 1'b0;
    if_a.trig = 4'b0101;
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (if_a.busy !== 4'b0100 || if_a.pulse !== 4'b0000 || if_a.miss !== 4'b0000) begin
        failures++;
        $display("FAIL freeze e%0d: busy=%b pulse=%b miss=%b required 0100/0000/0000",
                 e, if_a.busy, if_a.pulse, if_a.miss);
      end
    end
    if_a.en = 1'b1;
    if_a.trig = 4'b0000;
    tick();
    checks++;
    if (if_a.busy !== 4'b0100 || if_a.pulse !== 4'b0000) begin
      failures++;
      $display("FAIL unfreeze_1: busy=%b pulse=%b required 0100/0000", if_a.busy, if_a.pulse);
    end
    tick();
    checks++;
    if (if_a.busy !== 4'b0000 || if_a.pulse !== 4'b0000) begin
      failures++;
      $display("FAIL unfreeze_2: busy=%b pulse=%b required 0000/0000", if_a.busy, if_a.pulse);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if_a.en = 1'b1; if_a.trig = '0; if_a.clr_miss = '0;
    if_r.en = 1'b1; if_r.trig = '0; if_r.clr_miss = '0;
    if_e.en = 1'b1; if_e.trig = '0; if_e.clr_miss = '0;
    if_1.en = 1'b1; if_1.trig = '0; if_1.clr_miss = '0;
    #12 rst_n = 1'b1;
    test_reset();
    test_single_fire();
    test_held_level();
    test_retrigger();
    test_edge_mode();
    test_lock_one();
    test_enable_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
